// File: rtl/tach_bargraph_driver.sv
// Tachometer bargraph driver: maps a speed word to a smoothed LED level with
// fast attack / slow decay, a peak-hold segment, bar/dot modes and a blinking red redline.
module tach_bargraph_driver #(
   parameter int IN_WIDTH        = 9,
   parameter int N_LEDS          = 18,
   parameter int N_GREEN         = 8,
   parameter int OFFSET          = 16,
   parameter int STEP            = 17,
   parameter int REDLINE         = 15,
   parameter int TICK_DIV        = 50000,
   parameter int DECAY_TICKS     = 4,
   parameter int PEAK_HOLD_TICKS = 100,
   parameter int BLINK_TICKS     = 25,
   parameter int OUTPUT_POLARITY = 0
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          Signal_valid,
   input  logic [IN_WIDTH-1:0]           Signal,
   input  logic                          Mode,
   output logic [N_GREEN-1:0]            LEDG,
   output logic [N_LEDS-N_GREEN-1:0]     LEDR,
   output logic [$clog2(N_LEDS+1)-1:0]   Level,
   output logic                          Overrange
);

   localparam int LW    = $clog2(N_LEDS + 1);
   localparam int N_RED = N_LEDS - N_GREEN;
   localparam int TW    = $clog2(TICK_DIV + 1);
   localparam int DW    = $clog2(DECAY_TICKS + 1);
   localparam int HW    = $clog2(PEAK_HOLD_TICKS + 1);
   localparam int BW    = $clog2(BLINK_TICKS + 1);

   localparam logic [TW-1:0]      TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0]      DECAY_LAST = DW'(DECAY_TICKS - 1);
   localparam logic [HW-1:0]      HOLD_INIT  = HW'(PEAK_HOLD_TICKS);
   localparam logic [BW-1:0]      BLINK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [LW-1:0]      REDLINE_L  = LW'(REDLINE);
   localparam bit                 BLINK_EN   = (REDLINE != 0);
   localparam bit                 ACTIVE_HI  = (OUTPUT_POLARITY != 0);
   localparam logic [N_GREEN-1:0] LEDG_OFF   = ACTIVE_HI ? '0 : '1;
   localparam logic [N_RED-1:0]   LEDR_OFF   = ACTIVE_HI ? '0 : '1;

   // Computed in 32-bit so no Signal value can wrap before the clamp at N_LEDS.
   function automatic logic [LW-1:0] sat_level(input logic [IN_WIDTH-1:0] s);
      int v;
      int q;
      v = int'(s);
      if (v < OFFSET) return '0;
      q = 1 + (v - OFFSET) / STEP;
      return (q >= N_LEDS) ? LW'(N_LEDS) : LW'(q);
   endfunction

   function automatic logic is_over(input logic [IN_WIDTH-1:0] s);
      return int'(s) >= OFFSET + N_LEDS * STEP;
   endfunction

   logic [TW-1:0]      tick_cnt;
   logic               tick;
   logic [LW-1:0]      tgt_p0;
   logic               ovr_p0;
   logic [LW-1:0]      disp_p1;
   logic [DW-1:0]      dcnt;
   logic [LW-1:0]      peak_p1;
   logic [HW-1:0]      hold;
   logic [BW-1:0]      bcnt;
   logic               phase;
   logic [N_LEDS-1:0]  seg;
   logic [N_GREEN-1:0] ledg_n;
   logic [N_RED-1:0]   ledr_n;

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge Clk) begin
      if (Reset || tick) tick_cnt <= '0;
      else               tick_cnt <= tick_cnt + TW'(1);
   end

   // Stage p0: sample target level and overrange
   always_ff @(posedge Clk) begin
      if (Reset) begin
         tgt_p0 <= '0;
         ovr_p0 <= 1'b0;
      end else if (Signal_valid) begin
         tgt_p0 <= sat_level(Signal);
         ovr_p0 <= is_over(Signal);
      end
   end

   // Stage p1: smoothed display level, instant attack and tick-paced decay
   always_ff @(posedge Clk) begin
      if (Reset) begin
         disp_p1 <= '0;
         dcnt    <= '0;
      end else if (tgt_p0 > disp_p1) begin
         disp_p1 <= tgt_p0;
         dcnt    <= '0;
      end else if (tgt_p0 < disp_p1) begin
         if (tick) begin
            if (dcnt == DECAY_LAST) begin
               disp_p1 <= disp_p1 - LW'(1);
               dcnt    <= '0;
            end else begin
               dcnt <= dcnt + DW'(1);
            end
         end
      end else begin
         dcnt <= '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         peak_p1 <= '0;
         hold    <= '0;
      end else if (disp_p1 > peak_p1) begin
         peak_p1 <= disp_p1;
         hold    <= HOLD_INIT;
      end else if (tick) begin
         if (hold != '0)             hold    <= hold - HW'(1);
         else if (peak_p1 > disp_p1) peak_p1 <= peak_p1 - LW'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         bcnt  <= '0;
         phase <= 1'b1;
      end else if (BLINK_EN && disp_p1 >= REDLINE_L) begin
         if (tick) begin
            if (bcnt == BLINK_LAST) begin
               bcnt  <= '0;
               phase <= ~phase;
            end else begin
               bcnt <= bcnt + BW'(1);
            end
         end
      end else begin
         bcnt  <= '0;
         phase <= 1'b1;
      end
   end

   // seg[k-1] is segment k; bank MSBs carry the lowest segment of each bank.
   always_comb begin
      seg    = '0;
      ledg_n = '0;
      ledr_n = '0;
      for (int k = 1; k <= N_LEDS; k++) begin
         seg[k-1] = (Mode ? (k == int'(disp_p1) && disp_p1 != '0) : (k <= int'(disp_p1)))
                  | (k == int'(peak_p1) && peak_p1 != '0);
      end
      for (int g = 0; g < N_GREEN; g++) ledg_n[N_GREEN-1-g] = seg[g];
      for (int r = 0; r < N_RED; r++)   ledr_n[N_RED-1-r]   = seg[N_GREEN+r] & phase;
   end

   // Stage p2: registered LED pins
   always_ff @(posedge Clk) begin
      if (Reset) begin
         LEDG <= LEDG_OFF;
         LEDR <= LEDR_OFF;
      end else begin
         LEDG <= ACTIVE_HI ? ledg_n : ~ledg_n;
         LEDR <= ACTIVE_HI ? ledr_n : ~ledr_n;
      end
   end

   assign Level     = disp_p1;
   assign Overrange = ovr_p0;

endmodule

// File: tb/tb_tach_bargraph_driver.sv
// Bench for tach_bargraph_driver with a short prescaler: vector table plus
// hand-written decay, peak-hold, blink and reset sequences.
module tb_tach_bargraph_driver;

   localparam int TICK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic [8:0] sig = '0;
   logic       mode = 1'b0;
   logic [7:0] ledg;
   logic [9:0] ledr;
   logic [4:0] level;
   logic       ovr;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   tach_bargraph_driver #(.TICK_DIV(TICK_DIV)) dut (
      .Clk(clk), .Reset(rst), .Signal_valid(valid), .Signal(sig), .Mode(mode),
      .LEDG(ledg), .LEDR(ledr), .Level(level), .Overrange(ovr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [8:0] sig;
      logic       mode;
      logic [4:0] lvl;
      logic [7:0] ledg;
      logic [9:0] ledr;
      logic       ovr;
   } vec_t;

   vec_t vecs[10];
   vec_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Present one sample for a single edge, then leave the bus idle.
   task automatic drive(input logic [8:0] s, input logic m);
      @(negedge clk);
      sig = s; valid = 1'b1; mode = m;
      @(negedge clk);
      valid = 1'b0; sig = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      int t0, t1, t18, first_dec, last_dec, n_dec, bad, off_cyc, n_tog, first_tog, last_tog;
      logic [4:0] prev_lvl;
      logic [9:0] prev_ledr, ledr_at_off, ledr_next, ledr_first_tog;

      vecs[0] = '{9'd15,  1'b0, 5'd0,  8'hFF, 10'h3FF, 1'b0};
      vecs[1] = '{9'd16,  1'b0, 5'd1,  8'h7F, 10'h3FF, 1'b0};
      vecs[2] = '{9'd60,  1'b1, 5'd3,  8'hDF, 10'h3FF, 1'b0};
      vecs[3] = '{9'd100, 1'b1, 5'd5,  8'hF7, 10'h3FF, 1'b0};
      vecs[4] = '{9'd150, 1'b0, 5'd8,  8'h00, 10'h3FF, 1'b0};
      vecs[5] = '{9'd167, 1'b0, 5'd9,  8'h00, 10'h1FF, 1'b0};
      vecs[6] = '{9'd200, 1'b0, 5'd11, 8'h00, 10'h07F, 1'b0};
      vecs[7] = '{9'd250, 1'b1, 5'd14, 8'hFF, 10'h3EF, 1'b0};
      vecs[8] = '{9'd321, 1'b0, 5'd18, 8'h00, 10'h000, 1'b0};
      vecs[9] = '{9'd322, 1'b0, 5'd18, 8'h00, 10'h000, 1'b1};

      repeat (2) @(negedge clk);
      chk("reset_ledg", 32'(ledg), 32'h0FF);
      chk("reset_ledr", 32'(ledr), 32'h3FF);
      chk("reset_level", 32'(level), 32'd0);
      chk("reset_ovr", 32'(ovr), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         sig = vecs[i].sig; valid = 1'b1; mode = vecs[i].mode;
         exp_q.push_back(vecs[i]);
         @(negedge clk);
         valid = 1'b0; sig = '0;
         chk($sformatf("vec%0d_ovr_e0", i), 32'(ovr), 32'(vecs[i].ovr));
         @(negedge clk);
         chk($sformatf("vec%0d_level_e1", i), 32'(level), 32'(vecs[i].lvl));
         if (i == 1) chk("latency_ledg_e1", 32'(ledg), 32'h0FF);
         @(negedge clk);
         if (i == 1) chk("latency_ledg_e2", 32'(ledg), 32'h07F);
         @(negedge clk);
         e = exp_q.pop_front();
         chk($sformatf("vec%0d_ledg", i), 32'(ledg), 32'(e.ledg));
         chk($sformatf("vec%0d_ledr", i), 32'(ledr), 32'(e.ledr));
         chk($sformatf("vec%0d_ovr", i), 32'(ovr), 32'(e.ovr));
      end

      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;

      // Full-scale hit, then release: decay pacing and peak hold
      drive(9'd400, 1'b0);
      chk("full_ovr", 32'(ovr), 32'd1);
      @(negedge clk);
      chk("full_level", 32'(level), 32'd18);
      t18 = cyc;
      sig = 9'd0; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      t0 = cyc;
      chk("release_ovr", 32'(ovr), 32'd0);
      prev_lvl = level; n_dec = 0; bad = 0; first_dec = -1; last_dec = 0;
      off_cyc = -1; ledr_at_off = '0; ledr_next = '0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (level != prev_lvl) begin
            if (level != prev_lvl - 5'd1) bad++;
            if (n_dec == 0) first_dec = cyc - t0;
            else if (cyc - last_dec != 4 * TICK_DIV) bad++;
            last_dec = cyc; n_dec++; prev_lvl = level;
         end
         if (off_cyc < 0 && ledr[0]) begin
            off_cyc = cyc; ledr_at_off = ledr;
         end
         if (off_cyc >= 0 && cyc == off_cyc + TICK_DIV) ledr_next = ledr;
      end
      chk("decay_steps", 32'(n_dec), 32'd18);
      chk("decay_final_level", 32'(level), 32'd0);
      chk("decay_first_in_13_16", 32'(first_dec >= 13 && first_dec <= 16), 32'd1);
      chk("decay_bad_steps", 32'(bad), 32'd0);
      chk("peak_hold_in_400_410", 32'(off_cyc - t18 >= 400 && off_cyc - t18 <= 410 && off_cyc >= 0), 32'd1);
      chk("peak_at_17", 32'(ledr_at_off), 32'h3FD);
      chk("peak_at_16", 32'(ledr_next), 32'h3FB);

      // Redline: blink period of the red bank while green stays lit
      drive(9'd300, 1'b0);
      @(negedge clk);
      chk("redline_level", 32'(level), 32'd17);
      t1 = cyc;
      prev_ledr = 10'h001; bad = 0; n_tog = 0; first_tog = -1; last_tog = 0; ledr_first_tog = '0;
      for (int c = 0; c < 420; c++) begin
         @(negedge clk);
         if (ledg != 8'h00 || level != 5'd17) bad++;
         if (ledr != 10'h001 && ledr != 10'h3FF) bad++;
         if (ledr != prev_ledr) begin
            if (n_tog == 0) begin
               first_tog = cyc - t1; ledr_first_tog = ledr;
            end else if (cyc - last_tog != 25 * TICK_DIV) bad++;
            last_tog = cyc; n_tog++; prev_ledr = ledr;
         end
      end
      chk("blink_bad", 32'(bad), 32'd0);
      chk("blink_toggles", 32'(n_tog >= 3), 32'd1);
      chk("blink_first_in_98_101", 32'(first_tog >= 98 && first_tog <= 101), 32'd1);
      chk("blink_off_value", 32'(ledr_first_tog), 32'h3FF);

      // Saturated input, then reset in the middle of decay
      drive(9'd511, 1'b0);
      chk("sat_ovr", 32'(ovr), 32'd1);
      @(negedge clk);
      chk("sat_level", 32'(level), 32'd18);
      drive(9'd0, 1'b0);
      repeat (30) @(negedge clk);
      chk("mid_decay", 32'(level < 5'd18 && level > 5'd0), 32'd1);
      rst = 1'b1; sig = 9'd400; valid = 1'b1;
      @(negedge clk);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_ovr", 32'(ovr), 32'd0);
      chk("rst_ledg", 32'(ledg), 32'h0FF);
      chk("rst_ledr", 32'(ledr), 32'h3FF);
      rst = 1'b0; valid = 1'b0; sig = '0;
      repeat (10) @(negedge clk);
      chk("post_rst_level", 32'(level), 32'd0);
      chk("post_rst_ledg", 32'(ledg), 32'h0FF);
      chk("post_rst_ledr", 32'(ledr), 32'h3FF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
